// File: rtl/writeback_buffer.sv
// rtl/writeback_buffer.sv - in-order register write-back queue feeding registers_bank; forwarding lookup under WB_FORWARD_EN
module writeback_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [31:0]              alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [4:0]               mem_rd,
  input  logic [31:0]              mem_data,
  output logic                     mem_ready,
  output logic [4:0]               RD,
  output logic                     write_reg,
  output logic [31:0]              write_data,
  input  logic [4:0]               fwd_rs,
  input  logic [4:0]               fwd_rt,
  output logic                     fwd_rs_hit,
  output logic                     fwd_rt_hit,
  output logic [31:0]              fwd_rs_data,
  output logic [31:0]              fwd_rt_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    rd_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_next;
  logic [CW-1:0] push_cnt;
  logic          pop;
  logic          mem_acc;
  logic          alu_acc;
  logic          mem_push;
  logic          alu_push;
  logic          overflow;

  // Readiness depends only on the registered occupancy, never on this cycle's drain.
  assign mem_ready = (count_q <= CW'(DEPTH - 1));
  assign alu_ready = (count_q <= CW'(DEPTH - 2)) || ((count_q == CW'(DEPTH - 1)) && !mem_valid);

  assign mem_acc  = mem_valid && mem_ready;
  assign alu_acc  = alu_valid && alu_ready;
  // r0 results complete the handshake but are dropped; the bank must never see them.
  assign mem_push = mem_acc && (mem_rd != 5'd0);
  assign alu_push = alu_acc && (alu_rd != 5'd0);
  assign push_cnt = CW'(mem_push) + CW'(alu_push);

  assign pop        = (count_q != '0);
  assign count_next = count_q + push_cnt - CW'(pop);
  assign overflow   = (alu_valid && !alu_ready) || (mem_valid && !mem_ready);

  assign count      = count_q;
  assign write_reg  = pop;
  assign RD         = pop ? rd_q[head] : 5'd0;
  assign write_data = pop ? data_q[head] : 32'd0;

  // Pointer, occupancy and sticky error state; reset discards all pending writes at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count_q      <= '0;
      err_overflow <= 1'b0;
    end else begin
      head    <= head + PW'(pop);
      tail    <= tail + PW'(push_cnt);
      count_q <= count_next;
      if (overflow) begin
        err_overflow <= 1'b1;
      end
    end
  end

  // Entry storage: the load goes in first (older), the ALU result right behind it.
  always_ff @(posedge clk) begin
    if (mem_push) begin
      rd_q[tail]   <= mem_rd;
      data_q[tail] <= mem_data;
    end
    if (alu_push) begin
      rd_q[tail + PW'(mem_push)]   <= alu_rd;
      data_q[tail + PW'(mem_push)] <= alu_data;
    end
  end

`ifdef WB_FORWARD_EN
  // Walk occupied entries oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    fwd_rs_hit  = 1'b0;
    fwd_rs_data = 32'd0;
    fwd_rt_hit  = 1'b0;
    fwd_rt_data = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        if ((fwd_rs != 5'd0) && (rd_q[head + PW'(i)] == fwd_rs)) begin
          fwd_rs_hit  = 1'b1;
          fwd_rs_data = data_q[head + PW'(i)];
        end
        if ((fwd_rt != 5'd0) && (rd_q[head + PW'(i)] == fwd_rt)) begin
          fwd_rt_hit  = 1'b1;
          fwd_rt_data = data_q[head + PW'(i)];
        end
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd  = ^{fwd_rs, fwd_rt};
  assign fwd_rs_hit  = 1'b0;
  assign fwd_rt_hit  = 1'b0;
  assign fwd_rs_data = 32'd0;
  assign fwd_rt_data = 32'd0;
`endif

endmodule

// File: tb/tb_writeback_buffer.sv
// tb/tb_writeback_buffer.sv - table-driven scoreboard bench for writeback_buffer
module tb_writeback_buffer;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [4:0]  RD;
  logic        write_reg;
  logic [31:0] write_data;
  logic [4:0]  fwd_rs;
  logic [4:0]  fwd_rt;
  logic        fwd_rs_hit;
  logic        fwd_rt_hit;
  logic [31:0] fwd_rs_data;
  logic [31:0] fwd_rt_data;
  logic [2:0]  count;
  logic        err_overflow;

  writeback_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .RD(RD), .write_reg(write_reg), .write_data(write_data),
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .fwd_rs_hit(fwd_rs_hit), .fwd_rt_hit(fwd_rt_hit),
    .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data),
    .count(count), .err_overflow(err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdata;
    logic [4:0]  fa;
    logic [4:0]  fb;
    logic        e_ar;
    logic        e_mr;
    int          e_cnt;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t  exp_q[$];
  logic err_exp;
  int   n_vec;
  int   n_miss;
  vec_t tbl[19];

  function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                              input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
                              input logic [4:0] fa, input logic [4:0] fb,
                              input logic e_ar, input logic e_mr, input int e_cnt);
    vec_t v;
    v.av = av; v.ard = ard; v.adata = adata;
    v.mv = mv; v.mrd = mrd; v.mdata = mdata;
    v.fa = fa; v.fb = fb;
    v.e_ar = e_ar; v.e_mr = e_mr; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Youngest pending match wins; index 0 never hits; nothing when forwarding is compiled out.
  task automatic fwd_model(input logic [4:0] idx, output logic hit, output logic [31:0] data);
    hit  = 1'b0;
    data = 32'd0;
`ifdef WB_FORWARD_EN
    foreach (exp_q[i]) begin
      if (idx != 5'd0 && exp_q[i].rd == idx) begin
        hit  = 1'b1;
        data = exp_q[i].data;
      end
    end
`endif
  endtask

  task automatic apply(input vec_t v, input string tag);
    logic        ehit;
    logic [31:0] edat;
    int          mc;
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.adata;
    mem_valid = v.mv; mem_rd = v.mrd; mem_data = v.mdata;
    fwd_rs = v.fa; fwd_rt = v.fb;
    #1;
    mc = exp_q.size();
    chk({tag, " alu_ready"}, alu_ready, v.e_ar);
    chk({tag, " mem_ready"}, mem_ready, v.e_mr);
    chk({tag, " write_reg"}, write_reg, (mc != 0));
    if (mc != 0) begin
      chk({tag, " RD"}, RD, exp_q[0].rd);
      chk({tag, " write_data"}, write_data, exp_q[0].data);
    end else begin
      chk({tag, " RD idle"}, RD, 32'd0);
      chk({tag, " write_data idle"}, write_data, 32'd0);
    end
    fwd_model(v.fa, ehit, edat);
    chk({tag, " rs_hit"}, fwd_rs_hit, ehit);
    chk({tag, " rs_data"}, fwd_rs_data, edat);
    fwd_model(v.fb, ehit, edat);
    chk({tag, " rt_hit"}, fwd_rt_hit, ehit);
    chk({tag, " rt_data"}, fwd_rt_data, edat);
    if ((v.av && !v.e_ar) || (v.mv && !v.e_mr)) err_exp = 1'b1;
    if (mc != 0) void'(exp_q.pop_front());
    if (v.mv && v.e_mr && v.mrd != 5'd0) exp_q.push_back('{v.mrd, v.mdata});
    if (v.av && v.e_ar && v.ard != 5'd0) exp_q.push_back('{v.ard, v.adata});
    @(posedge clk);
    #1;
    chk({tag, " count"}, count, v.e_cnt);
    chk({tag, " err_overflow"}, err_overflow, err_exp);
  endtask

  initial begin
    n_vec = 0; n_miss = 0; err_exp = 1'b0;
    //            av ard  adata   mv mrd mdata    fa fb ar mr cnt
    tbl[0]  = mk(1, 5, 32'h1234, 0, 0, 32'h0,    5, 0, 1, 1, 1);
    tbl[1]  = mk(0, 0, 32'h0,    0, 0, 32'h0,    5, 5, 1, 1, 0);
    tbl[2]  = mk(0, 0, 32'h0,    0, 0, 32'h0,    5, 0, 1, 1, 0);
    tbl[3]  = mk(1, 3, 32'hBBBB, 1, 3, 32'hAAAA, 3, 3, 1, 1, 2);
    tbl[4]  = mk(0, 0, 32'h0,    0, 0, 32'h0,    3, 2, 1, 1, 1);
    tbl[5]  = mk(0, 0, 32'h0,    0, 0, 32'h0,    3, 1, 1, 1, 0);
    tbl[6]  = mk(1, 2, 32'h22,   1, 1, 32'h11,   1, 2, 1, 1, 2);
    tbl[7]  = mk(1, 4, 32'h44,   1, 3, 32'h33,   1, 2, 1, 1, 3);
    tbl[8]  = mk(1, 6, 32'h66,   1, 5, 32'h55,   3, 4, 0, 1, 3);
    tbl[9]  = mk(1, 6, 32'h66,   1, 7, 32'h77,   5, 6, 0, 1, 3);
    tbl[10] = mk(1, 6, 32'h66,   0, 0, 32'h0,    7, 4, 1, 1, 3);
    tbl[11] = mk(0, 0, 32'h0,    0, 0, 32'h0,    6, 5, 1, 1, 2);
    tbl[12] = mk(0, 0, 32'h0,    0, 0, 32'h0,    6, 7, 1, 1, 1);
    tbl[13] = mk(0, 0, 32'h0,    0, 0, 32'h0,    6, 0, 1, 1, 0);
    tbl[14] = mk(0, 0, 32'h0,    0, 0, 32'h0,    6, 0, 1, 1, 0);
    tbl[15] = mk(1, 0, 32'hFFFF, 0, 0, 32'h0,    0, 0, 1, 1, 0);
    tbl[16] = mk(0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 1, 1, 0);
    tbl[17] = mk(1, 8, 32'h88,   1, 0, 32'h1,    8, 0, 1, 1, 1);
    tbl[18] = mk(0, 0, 32'h0,    0, 0, 32'h0,    8, 0, 1, 1, 0);

    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    fwd_rs = 5'd0; fwd_rt = 5'd0;
    #1;
    chk("reset count", count, 32'd0);
    chk("reset write_reg", write_reg, 32'd0);
    chk("reset RD", RD, 32'd0);
    chk("reset write_data", write_data, 32'd0);
    chk("reset alu_ready", alu_ready, 32'd1);
    chk("reset mem_ready", mem_ready, 32'd1);
    chk("reset err_overflow", err_overflow, 32'd0);
    chk("reset rs_hit", fwd_rs_hit, 32'd0);
    chk("reset rs_data", fwd_rs_data, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      apply(tbl[i], $sformatf("v%0d", i));
    end

    // Reset while three writes are pending: everything drops without a clock edge.
    apply(mk(1, 11, 32'hB0, 1, 10, 32'hA0, 0, 0, 1, 1, 2), "rst_fill0");
    apply(mk(1, 13, 32'hD0, 1, 12, 32'hC0, 0, 0, 1, 1, 3), "rst_fill1");
    alu_valid = 1'b0; mem_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midreset write_reg", write_reg, 32'd0);
    chk("midreset count", count, 32'd0);
    chk("midreset RD", RD, 32'd0);
    chk("midreset err_overflow", err_overflow, 32'd0);
    chk("midreset mem_ready", mem_ready, 32'd1);
    #2;
    reset = 1'b0;
    exp_q.delete();
    err_exp = 1'b0;
    apply(mk(1, 9, 32'h99, 0, 0, 32'h0, 9, 0, 1, 1, 1), "post_rst0");
    apply(mk(0, 0, 32'h0, 0, 0, 32'h0, 9, 0, 1, 1, 0), "post_rst1");
    apply(mk(0, 0, 32'h0, 0, 0, 32'h0, 9, 0, 1, 1, 0), "post_rst2");
    chk("scoreboard drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
